multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Control unit for the multicycle RV32I subset datapath: add, sub, and, or, slt, addi, andi, ori, slti, lw, sw, beq, jal. It sequences the shared PC/ALU/memory datapath through a Moore state machine, one state per cycle. A `mem_ready` handshake lets the unified instruction/data memory stall fetch and load/store states. It sits beside the datapath (flopr/flopenr registers, mux2/mux3, regfile) and drives every select and enable.

## Interface
- No parameters; all encodings are fixed constants in the package.
- `clk` in 1 — rising-edge clock.
- `reset` in 1 — asynchronous, active-high; clock `clk`.
- `op` in 7 — instruction opcode from the instruction register (IR).
- `funct3` in 3 — IR[14:12].
- `funct7b5` in 1 — IR[30].
- `zero` in 1 — ALU zero flag.
- `mem_ready` in 1 — memory completes the current access this cycle.
- `pc_write` out 1 — PC register enable.
- `adr_src` out 1 — memory address select: 0 = PC, 1 = ALUOut.
- `mem_write` out 1 — memory write enable.
- `ir_write` out 1 — IR and OldPC enable.
- `result_src` out 2 — result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `alu_src_a` out 2 — ALU operand A: 00 = PC, 01 = OldPC, 10 = rd1.
- `alu_src_b` out 2 — ALU operand B: 00 = rd2, 01 = ImmExt, 10 = 4.
- `alu_control` out 3 — ALU function: add 000, sub 001, and 010, or 011, slt 101.
- `imm_src` out 2 — immediate format: I 00, S 01, B 10, J 11.
- `reg_write` out 1 — register file write enable.
- `instr_done` out 1 — one-cycle pulse in the final state of each legal instruction.
- `illegal` out 1 — one-cycle pulse in DECODE when the opcode is unsupported.

## Operation
- Reset value: state = FETCH.
  - While `reset` is high, `pc_write`, `ir_write`, `reg_write`, `mem_write`, `instr_done` and `illegal` are forced to 0.
- `pc_write` = (Branch & `zero`) | PCUpdate.
- `imm_src` is decoded combinationally from `op`:
  - lw and I-ALU → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - anything else → 00
- ALU decoder, ALUOp 00 → add; ALUOp 01 → sub; ALUOp 10 decodes by `funct3`:
  - 000 → sub if `funct7b5` & `op[5]`, else add
  - 010 → slt
  - 110 → or
  - 111 → and
  - any other `funct3` → add
- States (unlisted outputs are 0; ALUOp 00 unless stated):
  - **FETCH**: `adr_src`=0, A=00, B=10, `result_src`=10.
    - `ir_write` and PCUpdate are asserted only when `mem_ready`=1.
    - `mem_ready`=1 → DECODE; otherwise stay.
  - **DECODE**: A=01, B=01 (branch/jump target into ALUOut).
    - lw, sw → MEMADR; R-type → EXECR; I-ALU → EXECI; beq → BEQ; jal → JAL.
    - Any other opcode → FETCH, with `illegal`=1.
  - **MEMADR**: A=10, B=01. lw → MEMREAD; sw → MEMWRITE.
  - **MEMREAD**: `adr_src`=1, `result_src`=00. `mem_ready` → MEMWB; otherwise stay.
  - **MEMWB**: `result_src`=01, `reg_write`, `instr_done` → FETCH.
  - **MEMWRITE**: `adr_src`=1, `mem_write` held for the whole stall. `mem_ready` → FETCH with `instr_done`; otherwise stay.
  - **EXECR**: A=10, B=00, ALUOp 10 → ALUWB.
  - **EXECI**: A=10, B=01, ALUOp 10 → ALUWB.
  - **ALUWB**: `result_src`=00, `reg_write`, `instr_done` → FETCH.
  - **BEQ**: A=10, B=00, ALUOp 01, `result_src`=00, Branch, `instr_done` → FETCH.
  - **JAL**: A=01, B=10, `result_src`=00, PCUpdate → ALUWB (writes PC+4 to rd).
- Unencoded state values → FETCH.

## Timing
- All outputs are combinational from state, `op`, `funct3`, `funct7b5`, `zero` and `mem_ready`; no output registers.
- Latency with `mem_ready`=1:
  - lw 5 cycles
  - sw, R, I, jal 4 cycles
  - beq 3 cycles
  - illegal opcode 2 cycles
- Each cycle `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle; no state change and no register enable occurs in those cycles.
- `reset` asserted mid-instruction: the state goes to FETCH immediately (asynchronously). No write enable is asserted in the reset cycle.
- After deassertion, the first fetch completes on the first rising edge with `mem_ready`=1.

## Structure
- Package `mc_pkg`, shared with the datapath and bench, holds:
  - `state_t` enum (11 states)
  - opcode constants
  - `alu_control` constants
  - `imm_src`, `result_src` and src-select constants
- Sub-module `alu_decoder`: ALUOp, `funct3`, `funct7b5`, `op[5]` → `alu_control`; purely combinational.
- The main FSM and instruction decoder live in `multicycle_ctrl`.

## Test plan
- **Reset**: hold `reset` 2 cycles with `mem_ready`=1 → `ir_write`=`pc_write`=0 throughout. The first cycle after release gives `ir_write`=1, `pc_write`=1, `alu_src_b`=10.
- **sub**: op=0110011, funct3=000, funct7b5=1 → states FETCH, DECODE, EXECR (`alu_control`=001), ALUWB (`reg_write`=1, `instr_done`=1). Next cycle is FETCH.
- **lw stall**: op=0000011 with `mem_ready`=0 for 3 cycles in MEMREAD → 8 cycles total. `adr_src`=1 during the stall; `reg_write` is pulsed only in MEMWB with `result_src`=01.
- **beq**:
  - op=1100011, `zero`=1 → in BEQ `pc_write`=1, `alu_control`=001, `imm_src`=10.
  - Repeat with `zero`=0 → `pc_write`=0.
- **Illegal opcode and sw**:
  - op=0000000 → DECODE pulses `illegal`=1 and returns to FETCH; `instr_done` stays 0.
  - sw (0100011) → `mem_write`=1 only in MEMWRITE, `imm_src`=01.
- **Async reset mid-JAL**: assert `reset` in the JAL state, mid-cycle → state is FETCH before the next edge. No `reg_write` is asserted; `instr_done` does not pulse.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I subset: FSM states, opcodes and
// every datapath select value driven by multicycle_ctrl.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp plus instruction function fields to the ALU control code.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alu_control
);

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // addi shares funct3 000 with sub, so only R-type (op5) can subtract
          3'b000:  alu_control = (funct7b5 & op5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I subset datapath, with a
// mem_ready handshake that stalls fetch, load and store states.
module multicycle_ctrl
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_control,
  output logic [1:0] imm_src,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal
);

  state_t     state, state_next;
  logic [1:0] alu_op;
  logic       branch, pc_update;
  logic       mem_write_c, ir_write_c, reg_write_c, instr_done_c, illegal_c;

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    alu_op       = ALUOP_ADD;
    branch       = 1'b0;
    pc_update    = 1'b0;
    adr_src      = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_write_c  = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    result_src   = RES_ALUOUT;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RD2;
    case (state)
      FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write_c = mem_ready;
        pc_update  = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        // precompute the branch/jump target into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_RTYPE:     state_next = EXECR;
          OP_IALU:      state_next = EXECI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            state_next = FETCH;
            illegal_c  = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        result_src   = RES_DATA;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_next   = FETCH;
      end
      MEMWRITE: begin
        adr_src      = 1'b1;
        mem_write_c  = 1'b1;
        instr_done_c = mem_ready;
        if (mem_ready) state_next = FETCH;
      end
      EXECR: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECI: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        result_src   = RES_ALUOUT;
        reg_write_c  = 1'b1;
        instr_done_c = 1'b1;
        state_next   = FETCH;
      end
      BEQ: begin
        alu_src_a    = SRCA_RD1;
        alu_src_b    = SRCB_RD2;
        alu_op       = ALUOP_SUB;
        result_src   = RES_ALUOUT;
        branch       = 1'b1;
        instr_done_c = 1'b1;
        state_next   = FETCH;
      end
      JAL: begin
        // PC takes the target from ALUOut while OldPC+4 is computed for rd
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .op5         (op[5]),
    .alu_control (alu_control)
  );

  // enables are suppressed while reset is held so nothing is written mid-reset
  assign pc_write   = ((branch & zero) | pc_update) & ~reset;
  assign ir_write   = ir_write_c   & ~reset;
  assign mem_write  = mem_write_c  & ~reset;
  assign reg_write  = reg_write_c  & ~reset;
  assign instr_done = instr_done_c & ~reset;
  assign illegal    = illegal_c    & ~reset;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class through
// its states and checks the control outputs against hand-derived values.
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, mem_write, ir_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic       reg_write, instr_done, illegal;

  int n_assert = 0;
  int n_fail   = 0;

  multicycle_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .imm_src     (imm_src),
    .reg_write   (reg_write),
    .instr_done  (instr_done),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one cycle and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = OP_RTYPE; funct3 = 3'b000; funct7b5 = 1'b1;
    zero = 1'b0; mem_ready = 1'b1;

    // reset held two cycles with mem_ready high: no fetch enables
    #1;
    check("rst_ir_write_0", 4'(ir_write), 4'd0);
    check("rst_pc_write_0", 4'(pc_write), 4'd0);
    tick();
    check("rst_ir_write_1", 4'(ir_write), 4'd0);
    check("rst_pc_write_1", 4'(pc_write), 4'd0);
    tick();
    reset = 1'b0;
    #1;
    check("fetch_ir_write", 4'(ir_write), 4'd1);
    check("fetch_pc_write", 4'(pc_write), 4'd1);
    check("fetch_src_b",    4'(alu_src_b), 4'(SRCB_FOUR));
    check("fetch_res_src",  4'(result_src), 4'(RES_ALURESULT));

    // sub: FETCH DECODE EXECR ALUWB
    tick();
    check("sub_dec_src_a",   4'(alu_src_a), 4'(SRCA_OLDPC));
    check("sub_dec_src_b",   4'(alu_src_b), 4'(SRCB_IMM));
    check("sub_dec_ir_write", 4'(ir_write), 4'd0);
    check("sub_dec_alu",     4'(alu_control), 4'(ALU_ADD));
    tick();
    check("sub_exec_alu",   4'(alu_control), 4'(ALU_SUB));
    check("sub_exec_src_a", 4'(alu_src_a), 4'(SRCA_RD1));
    check("sub_exec_src_b", 4'(alu_src_b), 4'(SRCB_RD2));
    check("sub_exec_regw",  4'(reg_write), 4'd0);
    tick();
    check("sub_wb_regw", 4'(reg_write), 4'd1);
    check("sub_wb_done", 4'(instr_done), 4'd1);
    check("sub_wb_res",  4'(result_src), 4'(RES_ALUOUT));
    tick();
    check("sub_next_fetch", 4'(ir_write), 4'd1);

    // I-type or: op5=0 so funct7b5 must not matter
    op = OP_IALU; funct3 = 3'b110; funct7b5 = 1'b1;
    tick();
    tick();
    check("ori_exec_alu",  4'(alu_control), 4'(ALU_OR));
    check("ori_exec_src_b", 4'(alu_src_b), 4'(SRCB_IMM));
    funct3 = 3'b000;
    #1;
    check("addi_f7_ignored", 4'(alu_control), 4'(ALU_ADD));
    funct3 = 3'b010;
    #1;
    check("slti_alu", 4'(alu_control), 4'(ALU_SLT));
    tick();
    check("ori_wb_done", 4'(instr_done), 4'd1);
    tick();

    // fetch stall: mem_ready low holds FETCH with no enables
    mem_ready = 1'b0;
    #1;
    check("fstall_ir_write", 4'(ir_write), 4'd0);
    check("fstall_pc_write", 4'(pc_write), 4'd0);
    tick();
    check("fstall_still_fetch", 4'(alu_src_b), 4'(SRCB_FOUR));

    // lw with three stall cycles in MEMREAD: 8 cycles total
    op = OP_LW; funct3 = 3'b010; mem_ready = 1'b1;
    #1;
    check("lw_fetch_ir_write", 4'(ir_write), 4'd1);
    tick();
    check("lw_dec_imm", 4'(imm_src), 4'(IMM_I));
    tick();
    check("lw_adr_src_a", 4'(alu_src_a), 4'(SRCA_RD1));
    check("lw_adr_alu",   4'(alu_control), 4'(ALU_ADD));
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lw_stall_adr_src", 4'(adr_src), 4'd1);
      check("lw_stall_regw",    4'(reg_write), 4'd0);
      check("lw_stall_pcw",     4'(pc_write), 4'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("lw_read_adr_src", 4'(adr_src), 4'd1);
    check("lw_read_regw",    4'(reg_write), 4'd0);
    tick();
    check("lw_wb_regw", 4'(reg_write), 4'd1);
    check("lw_wb_res",  4'(result_src), 4'(RES_DATA));
    check("lw_wb_done", 4'(instr_done), 4'd1);
    tick();
    check("lw_next_fetch", 4'(ir_write), 4'd1);

    // beq taken then not taken in the same BEQ cycle
    op = OP_BEQ; funct3 = 3'b000; zero = 1'b1;
    tick();
    tick();
    check("beq_pcw_taken", 4'(pc_write), 4'd1);
    check("beq_alu",       4'(alu_control), 4'(ALU_SUB));
    check("beq_imm",       4'(imm_src), 4'(IMM_B));
    check("beq_done",      4'(instr_done), 4'd1);
    zero = 1'b0;
    #1;
    check("beq_pcw_not_taken", 4'(pc_write), 4'd0);
    tick();
    check("beq_next_fetch", 4'(ir_write), 4'd1);

    // illegal opcode: two cycles, no instr_done
    op = 7'b0000000;
    tick();
    check("ill_pulse", 4'(illegal), 4'd1);
    check("ill_done",  4'(instr_done), 4'd0);
    tick();
    check("ill_back_fetch", 4'(ir_write), 4'd1);
    check("ill_cleared",    4'(illegal), 4'd0);

    // sw with one stall cycle in MEMWRITE
    op = OP_SW; funct3 = 3'b010;
    tick();
    check("sw_dec_imm", 4'(imm_src), 4'(IMM_S));
    tick();
    check("sw_adr_memw", 4'(mem_write), 4'd0);
    tick();
    mem_ready = 1'b0;
    #1;
    check("sw_stall_memw", 4'(mem_write), 4'd1);
    check("sw_stall_adr",  4'(adr_src), 4'd1);
    check("sw_stall_done", 4'(instr_done), 4'd0);
    tick();
    mem_ready = 1'b1;
    #1;
    check("sw_write_memw", 4'(mem_write), 4'd1);
    check("sw_write_done", 4'(instr_done), 4'd1);
    tick();
    check("sw_fetch_memw", 4'(mem_write), 4'd0);

    // jal, then async reset mid-cycle in the JAL state
    op = OP_JAL;
    tick();
    tick();
    check("jal_pcw",   4'(pc_write), 4'd1);
    check("jal_src_a", 4'(alu_src_a), 4'(SRCA_OLDPC));
    check("jal_src_b", 4'(alu_src_b), 4'(SRCB_FOUR));
    check("jal_imm",   4'(imm_src), 4'(IMM_J));
    #2;
    reset = 1'b1;
    #1;
    check("jrst_state", 4'(dut.state), 4'(FETCH));
    check("jrst_regw",  4'(reg_write), 4'd0);
    check("jrst_pcw",   4'(pc_write), 4'd0);
    check("jrst_done",  4'(instr_done), 4'd0);
    tick();
    check("jrst_hold_regw", 4'(reg_write), 4'd0);
    check("jrst_hold_done", 4'(instr_done), 4'd0);
    reset = 1'b0;
    #1;
    check("jrst_release_ir_write", 4'(ir_write), 4'd1);
    tick();
    check("jrst_release_decode", 4'(alu_src_a), 4'(SRCA_OLDPC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
